// File: rtl/wptr_full_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wptr_full_ctrl_pkg
// Description : Shared dual-clock FIFO helpers. Gray/binary conversion used
//               by both the write-side and read-side pointer controllers,
//               plus the depth derivation from the address width.
// Revision    : 1.0 - initial release
// ============================================================================
package wptr_full_ctrl_pkg;

    // Widest pointer the helpers support. Narrower pointers are zero-extended
    // into this width; a zero-extended Gray code converts to a zero-extended
    // binary value, so callers simply truncate the result back.
    localparam int c_PTR_MAX_W = 32;

    function automatic logic [c_PTR_MAX_W-1:0] gray2bin(input logic [c_PTR_MAX_W-1:0] gray);
        logic [c_PTR_MAX_W-1:0] bin;
        bin[c_PTR_MAX_W-1] = gray[c_PTR_MAX_W-1];
        for (int i = c_PTR_MAX_W-2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic [c_PTR_MAX_W-1:0] bin2gray(input logic [c_PTR_MAX_W-1:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wptr_full_ctrl_sync.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff_chain
// Description : STAGES-deep flop chain for bringing a Gray-coded bus into the
//               clk domain. Pure flops, no logic between stages.
// Ports       : clk   - destination-domain clock
//               rst_n - synchronous active-low reset, clears every stage
//               i_d   - asynchronous input bus
//               o_q   - output of the last stage
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wptr_full_ctrl
// Description : Write-domain pointer and status controller for a dual-clock
//               FIFO. Synchronises the read pointer, advances the write
//               pointer, and produces full / almost-full / fill count /
//               sticky overflow.
// Ports       : wclk         - write clock
//               rst_n        - synchronous active-low reset
//               winc         - write request (ignored while full)
//               rptr         - Gray read pointer from the read domain
//               afull_thresh - almost-full threshold in words
//               clr_ovf      - clears the sticky overflow flag
//               wptr         - registered Gray write pointer (to read domain)
//               waddr        - registered binary RAM write address
//               full         - FIFO full
//               almost_full  - fill count >= afull_thresh
//               wcount       - registered write-side fill level
//               overflow     - sticky: write attempted while full
// Revision    : 1.0 - initial release
// ============================================================================
module wptr_full_ctrl
    import wptr_full_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic                  clr_ovf,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  overflow
);

    localparam int c_PW = ADDR_WIDTH + 1;

    logic [c_PW-1:0] r_wbin;
    logic [c_PW-1:0] w_rptr_sync;
    logic [c_PW-1:0] w_rbin_sync;
    logic [c_PW-1:0] w_wbin_next;
    logic [c_PW-1:0] w_wgray_next;
    logic [c_PW-1:0] w_full_match;
    logic [c_PW-1:0] w_count_next;
    logic            w_accept;

    sync_ff_chain #(
        .WIDTH  (c_PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_n (rst_n),
        .i_d   (rptr),
        .o_q   (w_rptr_sync)
    );

    assign w_rbin_sync  = c_PW'(gray2bin(c_PTR_MAX_W'(w_rptr_sync)));

    assign w_accept     = winc & ~full;
    assign w_wbin_next  = r_wbin + c_PW'(w_accept);
    assign w_wgray_next = c_PW'(bin2gray(c_PTR_MAX_W'(w_wbin_next)));

    // In Gray code, "DEPTH ahead" is the read pointer with its top two bits
    // inverted. Because rptr_sync lags the real read pointer, full can only
    // be held too long, never released too early.
    assign w_full_match = {~w_rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                            w_rptr_sync[ADDR_WIDTH-2:0]};

    // Modular difference; the extra MSB keeps DEPTH distinct from zero.
    assign w_count_next = w_wbin_next - w_rbin_sync;

    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            r_wbin      <= '0;
            wptr        <= '0;
            waddr       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wcount      <= '0;
            overflow    <= 1'b0;
        end else begin
            r_wbin      <= w_wbin_next;
            wptr        <= w_wgray_next;
            waddr       <= w_wbin_next[ADDR_WIDTH-1:0];
            full        <= (w_wgray_next == w_full_match);
            almost_full <= (w_count_next >= afull_thresh);
            wcount      <= w_count_next;
            // Set takes priority over clear so a rejected write is never lost.
            if (winc && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wptr_full_ctrl
// Description : Directed self-checking bench for wptr_full_ctrl with
//               ADDR_WIDTH=3 (DEPTH=8), SYNC_STAGES=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wptr_full_ctrl;

    logic       wclk;
    logic       rst_n;
    logic       winc;
    logic [3:0] rptr;
    logic [3:0] afull_thresh;
    logic       clr_ovf;
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic       full;
    logic       almost_full;
    logic [3:0] wcount;
    logic       overflow;

    int n_cmp;
    int n_err;

    wptr_full_ctrl #(
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (2)
    ) dut (
        .wclk         (wclk),
        .rst_n        (rst_n),
        .winc         (winc),
        .rptr         (rptr),
        .afull_thresh (afull_thresh),
        .clr_ovf      (clr_ovf),
        .wptr         (wptr),
        .waddr        (waddr),
        .full         (full),
        .almost_full  (almost_full),
        .wcount       (wcount),
        .overflow     (overflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] k4;
        n_cmp = 0;
        n_err = 0;

        // ---- reset with winc held high ----
        rst_n        = 1'b0;
        winc         = 1'b1;
        rptr         = 4'b0000;
        afull_thresh = 4'd6;
        clr_ovf      = 1'b0;
        step();
        step();
        chk("rst_wptr",     32'(wptr),        32'h0);
        chk("rst_waddr",    32'(waddr),       32'h0);
        chk("rst_full",     32'(full),        32'h0);
        chk("rst_afull",    32'(almost_full), 32'h0);
        chk("rst_wcount",   32'(wcount),      32'h0);
        chk("rst_overflow", 32'(overflow),    32'h0);

        // ---- fill to full, threshold 6 ----
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            k4 = 4'(k);
            chk("fill_wcount", 32'(wcount),      32'(k4));
            chk("fill_waddr",  32'(waddr),       32'(k4[2:0]));
            chk("fill_afull",  32'(almost_full), 32'(k >= 6));
            chk("fill_full",   32'(full),        32'(k == 8));
        end
        chk("fill_wptr", 32'(wptr), 32'hC);

        // ---- overflow: winc still high while full ----
        step();
        chk("ovf_set",   32'(overflow), 32'h1);
        chk("ovf_wptr",  32'(wptr),     32'hC);
        chk("ovf_waddr", 32'(waddr),    32'h0);
        chk("ovf_full",  32'(full),     32'h1);
        chk("ovf_count", 32'(wcount),   32'h8);
        clr_ovf = 1'b1;
        step();
        chk("ovf_set_wins", 32'(overflow), 32'h1);
        winc = 1'b0;
        step();
        chk("ovf_clear", 32'(overflow), 32'h0);
        clr_ovf = 1'b0;

        // ---- release latency: one word read ----
        rptr = 4'b0001;
        step();
        chk("rel_full_e1", 32'(full), 32'h1);
        step();
        chk("rel_full_e2", 32'(full), 32'h1);
        step();
        chk("rel_full_e3",  32'(full),        32'h0);
        chk("rel_count_e3", 32'(wcount),      32'h7);
        chk("rel_afull_e3", 32'(almost_full), 32'h1);

        // ---- drain: read side reaches 8 (Gray 1100) ----
        rptr = 4'b1100;
        step();
        step();
        step();
        chk("drain_count", 32'(wcount),      32'h0);
        chk("drain_full",  32'(full),        32'h0);
        chk("drain_afull", 32'(almost_full), 32'h0);
        chk("drain_wptr",  32'(wptr),        32'hC);

        // ---- wrap: 8 more writes take wbin from 8 to 16 == 0 ----
        winc = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            k4 = 4'(k);
            chk("wrap_wcount", 32'(wcount), 32'(k4));
            chk("wrap_waddr",  32'(waddr),  32'(k4[2:0]));
            chk("wrap_full",   32'(full),   32'(k == 8));
            if (k == 8) winc = 1'b0;
        end
        chk("wrap_wptr", 32'(wptr), 32'h0);
        // read side catches up to 16 (Gray 0000)
        rptr = 4'b0000;
        step();
        step();
        step();
        chk("wrap_end_count", 32'(wcount), 32'h0);
        chk("wrap_end_full",  32'(full),   32'h0);

        // ---- threshold 0: almost_full with an empty FIFO ----
        afull_thresh = 4'd0;
        step();
        chk("th0_afull", 32'(almost_full), 32'h1);
        chk("th0_count", 32'(wcount),      32'h0);

        // ---- threshold 9 (> DEPTH): never asserts, even when full ----
        afull_thresh = 4'd9;
        winc = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("th9_afull", 32'(almost_full), 32'h0);
            if (k == 8) winc = 1'b0;
        end
        chk("th9_full", 32'(full), 32'h1);

        // ---- threshold == DEPTH with 8 words held ----
        afull_thresh = 4'd8;
        step();
        chk("th8_afull", 32'(almost_full), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
